fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 61 ++++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The queue entry struct is sized by FETCH_DATA_WIDTH / FETCH_ADDRESS_WIDTH;
// fetch_unit's DATA_WIDTH / ADDRESS_WIDTH must match these values.
package fetch_pkg;

    localparam int INSTR_BYTES         = 4;
    localparam int FETCH_DATA_WIDTH    = 32;
    localparam int FETCH_ADDRESS_WIDTH = 8;
    localparam int FETCH_QUEUE_DEPTH   = 4;
    localparam int FETCH_COUNT_WIDTH   = $clog2(FETCH_QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic [FETCH_DATA_WIDTH-1:0]    instr;
        logic [FETCH_ADDRESS_WIDTH-1:0] pc;
    } fetch_entry_t;

    // Width needed to hold an occupancy value from 0 up to and including depth.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t. Head is presented combinationally.
// Flush is synchronous and wins over push/pop in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH       = FETCH_QUEUE_DEPTH,
    parameter int COUNT_WIDTH = countWidth(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           pushEntry,
    input  logic                   pop,
    output fetch_entry_t           headEntry,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   empty
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    fetch_entry_t           mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wrPtr;
    logic [PTR_WIDTH-1:0]   rdPtr;

    assign headEntry = mem[rdPtr];
    assign empty     = (count == '0);

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: PC generator, credit-limited request issue,
// in-order response capture into a prefetch queue, and redirect flushing.
// Responses already in flight at a redirect are counted in dropCnt and
// discarded as they arrive, so no wrong-path instruction reaches decode.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = FETCH_ADDRESS_WIDTH,
    parameter int                       DATA_WIDTH    = FETCH_DATA_WIDTH,
    parameter int                       QUEUE_DEPTH   = FETCH_QUEUE_DEPTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [DATA_WIDTH-1:0]    dec_instr,
    output logic [ADDRESS_WIDTH-1:0] dec_pc,
    output logic [ADDRESS_WIDTH-1:0] dec_pc_plus4,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_flushed
`endif
);

    localparam int                       CW          = countWidth(QUEUE_DEPTH);
    localparam logic [CW:0]              DEPTH_LIMIT = (CW+1)'(QUEUE_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP     = ADDRESS_WIDTH'(INSTR_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK  = ~ADDRESS_WIDTH'(INSTR_BYTES - 1);

    logic [ADDRESS_WIDTH-1:0] fetchPc;
    logic [ADDRESS_WIDTH-1:0] respPc;
    logic [ADDRESS_WIDTH-1:0] targetAligned;
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            outstandingNext;
    logic [CW-1:0]            dropCnt;
    logic [CW-1:0]            count;
    logic [CW:0]              inFlight;
    logic                     empty;
    logic                     issue;
    logic                     rspDrop;
    logic                     push;
    logic                     pop;
    fetch_entry_t             pushEntry;
    fetch_entry_t             headEntry;

    // Queue slots already committed (held or still in flight) bound new requests.
    assign inFlight       = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (inFlight < DEPTH_LIMIT);
    assign imem_addr      = fetchPc;
    assign issue          = imem_req_valid && imem_req_ready;

    // A response in the redirect cycle belongs to the old path, as do those covered by dropCnt.
    assign rspDrop        = imem_rsp_valid && (redirect_valid || (dropCnt != '0));
    assign push           = imem_rsp_valid && !rspDrop;
    assign pushEntry      = '{instr: imem_rsp_data, pc: respPc};

    assign dec_valid      = !rst && !empty && !redirect_valid;
    assign pop            = dec_valid && dec_ready;
    assign dec_instr      = empty ? '0 : headEntry.instr;
    assign dec_pc         = empty ? '0 : headEntry.pc;
    assign dec_pc_plus4   = empty ? '0 : headEntry.pc + PC_STEP;

    assign targetAligned  = redirect_target & ALIGN_MASK;

    // Outstanding count after this cycle's issue and response.
    always_comb begin
        outstandingNext = outstanding;
        if (issue && !imem_rsp_valid) begin
            outstandingNext = outstanding + 1'b1;
        end else if (!issue && imem_rsp_valid) begin
            outstandingNext = outstanding - 1'b1;
        end
    end

    // PC generation, credit and drop tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (redirect_valid) begin
                fetchPc <= targetAligned;
                respPc  <= targetAligned;
                dropCnt <= outstandingNext;
            end else begin
                if (issue) begin
                    fetchPc <= fetchPc + PC_STEP;
                end
                if (push) begin
                    respPc <= respPc + PC_STEP;
                end
                if (imem_rsp_valid && (dropCnt != '0)) begin
                    dropCnt <= dropCnt - 1'b1;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH       (QUEUE_DEPTH),
        .COUNT_WIDTH (CW)
    ) queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .pushEntry (pushEntry),
        .pop       (pop),
        .headEntry (headEntry),
        .count     (count),
        .empty     (empty)
    );

`ifdef FETCH_PERF_EN
    logic [CW:0] flushInc;
    logic [32:0] flushedSum;

    assign flushInc   = (redirect_valid ? {1'b0, count} : '0) + {{CW{1'b0}}, rspDrop};
    assign flushedSum = {1'b0, perf_flushed} + 33'(flushInc);

    // Saturating event counters: decode pops, and queue entries plus responses thrown away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_flushed <= flushedSum[32] ? '1 : flushedSum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit. Reference view: decode must see, in order,
// exactly the requests accepted since the last redirect/reset; request
// addresses run sequentially from the last (aligned) redirect target.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [7:0]  dec_pc;
    logic [7:0]  dec_pc_plus4;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_target = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (32),
        .QUEUE_DEPTH   (4),
        .RESET_PC      (8'h00)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .dec_pc_plus4    (dec_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_flushed    (perf_flushed)
`endif
    );

    typedef struct { int due; logic [31:0] data; } memRsp_t;
    typedef struct { logic [7:0] pc; logic [31:0] instr; } expEntry_t;

    memRsp_t   pending[$];
    expEntry_t expQ[$];
    memRsp_t   newRsp;
    expEntry_t popped;

    int         cyc = 0;
    int         lastDue = 0;
    int         latMin = 1;
    int         latMax = 1;
    int         lat;
    int         nChecks = 0;
    int         nFails = 0;
    int         issuedSinceReset = 0;
    int         popsSinceReset = 0;
    logic [7:0] expFetchPc = 8'h00;
    logic [7:0] epoch = 8'h00;
    logic [7:0] firstPopPc = 8'h00;
    logic [7:0] expPlus4;
    bit         firstPopSeen = 1'b0;
    bit         sawFc = 1'b0;

    function automatic logic [31:0] memWord(input logic [7:0] addr, input logic [7:0] ep);
        return {ep, 8'hC3, addr, ~addr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Request side: record accepted requests, schedule memory responses, track redirects.
    always @(negedge clk) begin
        if (!rst) begin
            if (redirect_valid) begin
                check("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
                expQ.delete();
                expFetchPc = redirect_target & 8'hFC;
                epoch      = epoch + 8'd1;
            end else if (imem_req_valid && imem_req_ready) begin
                check("imem_addr", 32'(imem_addr), 32'(expFetchPc));
                lat         = $urandom_range(latMax, latMin);
                newRsp.due  = (cyc + lat > lastDue) ? cyc + lat : lastDue + 1;
                lastDue     = newRsp.due;
                newRsp.data = memWord(expFetchPc, epoch);
                pending.push_back(newRsp);
                expQ.push_back('{pc: expFetchPc, instr: newRsp.data});
                expFetchPc = expFetchPc + 8'd4;
                issuedSinceReset++;
            end
        end
    end

    // Decode monitor: every pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && dec_valid && dec_ready) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_pop: got pc 0x%0h expected no entry (cycle %0d)", dec_pc, cyc);
            end else begin
                popped   = expQ.pop_front();
                expPlus4 = popped.pc + 8'd4;
                check("dec_pc", 32'(dec_pc), 32'(popped.pc));
                check("dec_instr", dec_instr, popped.instr);
                check("dec_pc_plus4", 32'(dec_pc_plus4), 32'(expPlus4));
                if (!firstPopSeen) begin
                    firstPopSeen = 1'b1;
                    firstPopPc   = popped.pc;
                end
                if (popped.pc == 8'hFC) sawFc = 1'b1;
            end
            popsSinceReset++;
        end
    end

    // One clock: advance, clear the redirect pulse, play the memory model.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (!rst && pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pending[0].data;
            void'(pending.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic doReset();
        rst              = 1'b1;
        imem_rsp_valid   = 1'b0;
        imem_rsp_data    = '0;
        redirect_valid   = 1'b0;
        dec_ready        = 1'b0;
        imem_req_ready   = 1'b0;
        pending.delete();
        expQ.delete();
        expFetchPc       = 8'h00;
        epoch            = epoch + 8'd1;
        lastDue          = 0;
        issuedSinceReset = 0;
        popsSinceReset   = 0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_instr", dec_instr, 32'd0);
        check("rst_dec_pc", 32'(dec_pc), 32'd0);
        check("rst_dec_pc_plus4", 32'(dec_pc_plus4), 32'd0);
        step();
        step();
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_flushed", perf_flushed, 32'd0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: single-cycle memory, decode always ready
        doReset();
        latMin = 1; latMax = 1;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        #1;
        check("s1_req_valid", 32'(imem_req_valid), 32'd1);
        check("s1_first_addr", 32'(imem_addr), 32'h00);
        step(); #1;
        check("s1_not_yet_valid", 32'(dec_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            check("s1_dec_valid", 32'(dec_valid), 32'd1);
            check("s1_dec_pc", 32'(dec_pc), 32'(k * 4));
            check("s1_dec_pc_plus4", 32'(dec_pc_plus4), 32'(k * 4 + 4));
        end

        // 2: decode stalled fills the queue, then drains in order
        doReset();
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        repeat (10) step();
        #1;
        check("s2_issued", 32'(issuedSinceReset), 32'd4);
        check("s2_req_blocked", 32'(imem_req_valid), 32'd0);
        check("s2_head_valid", 32'(dec_valid), 32'd1);
        dec_ready = 1'b1;
        repeat (4) step();
        #1;
        check("s2_pops", 32'(popsSinceReset), 32'd4);
        check("s2_issue_resumed", 32'(issuedSinceReset >= 5), 32'd1);

        // 3: latency-3 memory, redirect with two requests in flight
        doReset();
        latMin = 3; latMax = 3;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        step();
        step();
        redirect_valid  = 1'b1;
        redirect_target = 8'h40;
        firstPopSeen    = 1'b0;
        #1;
        check("s3_no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        repeat (10) step();
        #1;
        check("s3_popped", 32'(firstPopSeen), 32'd1);
        check("s3_first_pc", 32'(firstPopPc), 32'h40);
`ifdef FETCH_PERF_EN
        check("s3_perf_flushed", perf_flushed, 32'd2);
        check("s3_perf_fetched", perf_fetched, 32'(popsSinceReset));
`endif

        // 4: misaligned redirect target
        redirect_valid  = 1'b1;
        redirect_target = 8'h43;
        firstPopSeen    = 1'b0;
        step(); #1;
        check("s4_aligned_addr", 32'(imem_addr), 32'h40);
        repeat (12) step();
        #1;
        check("s4_first_pc", 32'(firstPopPc), 32'h40);

        // 5: PC wrap at the top of the address space
        redirect_valid  = 1'b1;
        redirect_target = 8'hF8;
        sawFc           = 1'b0;
        repeat (16) step();
        #1;
        check("s5_saw_fc", 32'(sawFc), 32'd1);

        // 6: asynchronous reset in mid-cycle with three entries queued
        doReset();
        latMin = 1; latMax = 1;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        step(); step(); step();
        imem_req_ready = 1'b0;
        step();
        #1;
        check("s6_pre_dec_valid", 32'(dec_valid), 32'd1);
        check("s6_pre_req_valid", 32'(imem_req_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("s6_dec_valid_drop", 32'(dec_valid), 32'd0);
        check("s6_req_valid_drop", 32'(imem_req_valid), 32'd0);
        doReset();
        imem_req_ready = 1'b1;
        #1;
        check("s6_restart_valid", 32'(imem_req_valid), 32'd1);
        check("s6_restart_addr", 32'(imem_addr), 32'h00);

        // Random traffic: random latency, backpressure and redirects
        latMin = 1; latMax = 4;
        for (int i = 0; i < 3000; i++) begin
            step();
            imem_req_ready = ($urandom_range(0, 3) != 0);
            dec_ready      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid  = 1'b1;
                redirect_target = 8'($urandom_range(0, 255));
            end
        end

        // Drain: stop issuing, let everything in flight reach decode
        step();
        imem_req_ready = 1'b0;
        dec_ready      = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (pending.size() == 0 && expQ.size() == 0) break;
            step();
        end
        repeat (2) step();
        #1;
        check("drain_lost_entries", 32'(expQ.size()), 32'd0);
        check("drain_dec_valid", 32'(dec_valid), 32'd0);
`ifdef FETCH_PERF_EN
        check("perf_fetched_total", perf_fetched, 32'(popsSinceReset));
        check("perf_flushed_total", perf_flushed, 32'(issuedSinceReset - popsSinceReset));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
